mux_arb_n: RTL and testbench

//   N-channel, WIDTH-bit multiplexer with a registered output and valid/ready

---
 rtl/mux_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/mux_arb_n.sv | 82 ++++++++
 tb/tb_mux_arb_n.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - mode constants and width helper shared by the mux/arbiter slice
package mux_pkg;

    localparam int MODE_STEER = 0;
    localparam int MODE_RR    = 1;
    localparam int MODE_PRIO  = 2;

    // Minimum index width for n items; at least 1 so a 2-channel mux still has a select bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-start arbiter; ptr tied to 0 gives fixed lowest-index priority
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    // Scan from ptr upward with wrap; the extra sum bit keeps ptr+k exact before folding back below N.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        sum          = '0;
        idx          = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
        if (!en) grant_onehot = '0;
    end

endmodule

// File: rtl/mux_arb_n.sv
// rtl/mux_arb_n.sv - N-channel registered mux with steered, round-robin or priority source selection
module mux_arb_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = MODE_STEER,
    localparam int SELW = clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src
);

    logic            load;
    logic            xfer;
    logic [N-1:0]    sel_onehot;
    logic [N-1:0]    req;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] arb_ptr;
    logic [SELW-1:0] next_ptr;
    logic [N-1:0]    grant_onehot;
    logic [SELW-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;

    assign load = ~out_valid | out_ready;

    // Out-of-range sel matches no channel, so steering simply yields no grant.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) sel_onehot[i] = 1'b1;
        end
    end

    assign req     = (MODE == MODE_STEER) ? (in_valid & sel_onehot) : in_valid;
    assign arb_ptr = (MODE == MODE_RR) ? ptr : '0;

    // Held in reset, nothing is accepted so pending inputs survive a reset untouched.
    rr_arbiter #(.N(N), .IW(SELW)) u_arb (
        .req          (req),
        .en           (load & reset),
        .ptr          (arb_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign in_ready = grant_onehot;
    assign xfer     = |grant_onehot;
    assign next_ptr = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_onehot[i]) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant_idx;
            if (MODE == MODE_RR) ptr <= next_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// tb/tb_mux_arb_n.sv - scoreboard bench for mux_arb_n in steer, round-robin, priority and N=3 configurations
module tb_mux_arb_n;
    import mux_pkg::*;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic [1:0] src;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic [3:0]  iv   [4];
    logic [31:0] id   [4];
    logic [1:0]  sel  [4];
    logic        ordy [4];

    logic [3:0][3:0] ir;
    logic [3:0]      ov;
    logic [3:0][7:0] od;
    logic [3:0][1:0] os;
    logic [2:0]      ir3;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [7:0] chan_data [4];
    initial begin
        chan_data[0] = 8'h11;
        chan_data[1] = 8'h22;
        chan_data[2] = 8'h33;
        chan_data[3] = 8'h44;
    end

    always #5 clk = ~clk;

    mux_arb_n #(.WIDTH(8), .N(4), .MODE(MODE_STEER)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .sel(sel[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_src(os[0]));
    mux_arb_n #(.WIDTH(8), .N(4), .MODE(MODE_RR)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .sel(sel[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_src(os[1]));
    mux_arb_n #(.WIDTH(8), .N(4), .MODE(MODE_PRIO)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .sel(sel[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_src(os[2]));
    mux_arb_n #(.WIDTH(8), .N(3), .MODE(MODE_STEER)) dut3 (
        .clk(clk), .reset(reset), .in_valid(iv[3][2:0]), .in_ready(ir3), .in_data(id[3][23:0]),
        .sel(sel[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .out_src(os[3]));
    assign ir[3] = {1'b0, ir3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] data, input logic [1:0] src);
        exp_t e;
        e.dut  = d;
        e.data = data;
        e.src  = src;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest expected word
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            for (int d = 0; d < 4; d++) begin
                if (ov[d] && ordy[d]) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL out_word: dut%0d presented data=%h src=%0d with nothing expected",
                                 d, od[d], os[d]);
                    end else begin
                        e = sb.pop_front();
                        if (e.dut != d || e.data !== od[d] || e.src !== os[d]) begin
                            bad++;
                            $display("FAIL out_word: got dut%0d data=%h src=%0d expected dut%0d data=%h src=%0d",
                                     d, od[d], os[d], e.dut, e.data, e.src);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            iv[d]   = 4'hF;
            id[d]   = 32'h44332211;
            sel[d]  = 2'd0;
            ordy[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_out_valid%0d", d), 32'(ov[d]), 32'h0);
            check($sformatf("reset_out_data%0d", d), 32'(od[d]), 32'h0);
            check($sformatf("reset_out_src%0d", d), 32'(os[d]), 32'h0);
            check($sformatf("reset_in_ready%0d", d), 32'(ir[d]), 32'h0);
            iv[d] = 4'h0;
        end
        reset = 1'b1;
        step();

        // Steered select of channel 2
        iv[0] = 4'hF; sel[0] = 2'd2;
        #1 check("steer_in_ready", 32'(ir[0]), 32'h4);
        push(0, 8'h33, 2'd2);
        step();
        iv[0] = 4'h0;
        step(); step();

        // Round-robin across all four channels
        iv[1] = 4'hF;
        for (int k = 0; k < 8; k++) begin
            push(1, chan_data[k % 4], 2'(k % 4));
            step();
            check("rr_out_valid", 32'(ov[1]), 32'h1);
        end
        iv[1] = 4'h0;
        step(); step();

        // Fixed priority: lowest valid index wins
        iv[2] = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1 check("prio_ready_1010", 32'(ir[2]), 32'h2);
            push(2, 8'h22, 2'd1);
            step();
        end
        iv[2] = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            #1 check("prio_ready_1000", 32'(ir[2]), 32'h8);
            push(2, 8'h44, 2'd3);
            step();
        end
        iv[2] = 4'h0;
        step(); step();

        // Backpressure: stall three cycles, sel wiggles meanwhile
        iv[0] = 4'hF; sel[0] = 2'd1;
        #1 check("bp_first_ready", 32'(ir[0]), 32'h2);
        push(0, 8'h22, 2'd1);
        step();
        ordy[0] = 1'b0; sel[0] = 2'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_held_data", 32'(od[0]), 32'h22);
            check("bp_held_valid", 32'(ov[0]), 32'h1);
            check("bp_ready_zero", 32'(ir[0]), 32'h0);
            step();
        end
        sel[0] = 2'd0; ordy[0] = 1'b1;
        #1 check("bp_release_ready", 32'(ir[0]), 32'h1);
        push(0, 8'h11, 2'd0);
        step();
        iv[0] = 4'h0;
        check("bp_next_data", 32'(od[0]), 32'h11);
        check("bp_next_src", 32'(os[0]), 32'h0);
        step(); step();

        // N=3 with an out-of-range select
        iv[3] = 4'h7; sel[3] = 2'd0;
        #1 check("n3_ready_sel0", 32'(ir[3]), 32'h1);
        push(3, 8'h11, 2'd0);
        step();
        sel[3] = 2'd3;
        #1 check("n3_ready_sel3", 32'(ir[3]), 32'h0);
        step();
        check("n3_drained", 32'(ov[3]), 32'h0);
        step();
        check("n3_stays_empty", 32'(ov[3]), 32'h0);
        iv[3] = 4'h0;

        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
